// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt flag/enable controller with edge detect, priority vector and register read port
module irq_ctrl #(
   parameter logic [15:0] IF_ADDR = 16'hFF0F,
   parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic [15:0] A,
   input  logic [7:0]  D_IN,
   input  logic        WR,
   input  logic        RD,
   output logic [7:0]  D_OUT,
   output logic        D_OUT_EN,
   input  logic [4:0]  INT_REQ,
   output logic [7:0]  CPU_IRQ_TRIG,
   input  logic [7:0]  CPU_IRQ_ACK,
   output logic [2:0]  INT_VEC,
   output logic        WAKE
);

   logic [4:0] req_q, req_d;
   logic [4:0] if_q, if_d;
   logic [7:0] ie_q, ie_d;
   logic [7:0] dout_q, dout_d;
   logic       dout_en_q, dout_en_d;

   logic       wr_if, wr_ie, rd_if, rd_ie;
   logic [4:0] req_edge;
   logic [4:0] pending;

   assign wr_if    = WR && (A == IF_ADDR);
   assign wr_ie    = WR && (A == IE_ADDR);
   assign rd_if    = RD && (A == IF_ADDR);
   assign rd_ie    = RD && (A == IE_ADDR);
   assign req_edge = INT_REQ & ~req_q;
   assign pending  = if_q & ie_q[4:0];

   // Next-state for flags: a fresh request edge beats a CPU write, which beats an acknowledge.
   always_comb begin
      req_d = INT_REQ;
      ie_d  = wr_ie ? D_IN : ie_q;
      if_d  = if_q;
      for (int n = 0; n < 5; n++) begin
         if (req_edge[n])
            if_d[n] = 1'b1;
         else if (wr_if)
            if_d[n] = D_IN[n];
         else if (CPU_IRQ_ACK[n])
            if_d[n] = 1'b0;
      end
   end

   // Read data is taken from the pre-update register value and presented one cycle later.
   always_comb begin
      dout_d    = 8'h00;
      dout_en_d = 1'b0;
      if (rd_if) begin
         dout_d    = {3'b111, if_q};
         dout_en_d = 1'b1;
      end else if (rd_ie) begin
         dout_d    = ie_q;
         dout_en_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         req_q     <= 5'h00;
         if_q      <= 5'h00;
         ie_q      <= 8'h00;
         dout_q    <= 8'h00;
         dout_en_q <= 1'b0;
      end else begin
         req_q     <= req_d;
         if_q      <= if_d;
         ie_q      <= ie_d;
         dout_q    <= dout_d;
         dout_en_q <= dout_en_d;
      end
   end

   // Priority encode: lowest pending bit wins, zero when nothing pending.
   always_comb begin
      INT_VEC = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (pending[i])
            INT_VEC = i[2:0];
      end
   end

   assign CPU_IRQ_TRIG = {3'b000, pending};
   assign WAKE         = |pending;
   assign D_OUT        = dout_q;
   assign D_OUT_EN     = dout_en_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard testbench for irq_ctrl
module tb_irq_ctrl;

   localparam logic [15:0] IF_A = 16'hFF0F;
   localparam logic [15:0] IE_A = 16'hFFFF;

   logic        CLK = 1'b0;
   logic        nRESET;
   logic [15:0] A;
   logic [7:0]  D_IN;
   logic        WR;
   logic        RD;
   logic [7:0]  D_OUT;
   logic        D_OUT_EN;
   logic [4:0]  INT_REQ;
   logic [7:0]  CPU_IRQ_TRIG;
   logic [7:0]  CPU_IRQ_ACK;
   logic [2:0]  INT_VEC;
   logic        WAKE;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   irq_ctrl dut (
      .CLK(CLK), .nRESET(nRESET), .A(A), .D_IN(D_IN), .WR(WR), .RD(RD),
      .D_OUT(D_OUT), .D_OUT_EN(D_OUT_EN), .INT_REQ(INT_REQ),
      .CPU_IRQ_TRIG(CPU_IRQ_TRIG), .CPU_IRQ_ACK(CPU_IRQ_ACK),
      .INT_VEC(INT_VEC), .WAKE(WAKE)
   );

   always #5 CLK = ~CLK;

   // Monitor: every presented read is matched against the next queued expectation.
   always @(negedge CLK) begin
      logic [7:0] e;
      if (D_OUT_EN) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: D_OUT=%02h with no read outstanding", D_OUT);
         end else begin
            e = exp_q.pop_front();
            if (D_OUT !== e) begin
               errors++;
               $display("FAIL rd_data: got %02h expected %02h", D_OUT, e);
            end
         end
      end else begin
         checks++;
         if (D_OUT !== 8'h00) begin
            errors++;
            $display("FAIL rd_idle: D_OUT=%02h expected 00", D_OUT);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      WR = 1'b0; RD = 1'b0; CPU_IRQ_ACK = 8'h00;
   endtask

   task automatic wr(input logic [15:0] addr, input logic [7:0] data);
      A = addr; D_IN = data; WR = 1'b1;
      tick();
   endtask

   task automatic rd(input logic [15:0] addr, input logic [7:0] expv);
      A = addr; RD = 1'b1;
      exp_q.push_back(expv);
      tick();
   endtask

   task automatic chk(input string name, input logic [7:0] trig, input logic [2:0] vec, input logic wake);
      checks++;
      if (CPU_IRQ_TRIG !== trig || INT_VEC !== vec || WAKE !== wake) begin
         errors++;
         $display("FAIL %s: trig=%02h vec=%0d wake=%0b expected trig=%02h vec=%0d wake=%0b",
                  name, CPU_IRQ_TRIG, INT_VEC, WAKE, trig, vec, wake);
      end
   endtask

   initial begin
      nRESET = 1'b0; A = 16'h0000; D_IN = 8'h00; WR = 1'b0; RD = 1'b0;
      INT_REQ = 5'h00; CPU_IRQ_ACK = 8'h00;
      tick(); tick();
      chk("reset", 8'h00, 3'd0, 1'b0);
      nRESET = 1'b1;

      // Enable all, single timer pulse
      wr(IE_A, 8'h1F);
      rd(IE_A, 8'h1F);
      INT_REQ = 5'h04; tick(); INT_REQ = 5'h00;
      chk("timer_edge", 8'h04, 3'd2, 1'b1);
      rd(IF_A, 8'hE4);

      // Add STAT, then acknowledge it
      INT_REQ = 5'h02; tick(); INT_REQ = 5'h00;
      chk("if06", 8'h06, 3'd1, 1'b1);
      CPU_IRQ_ACK = 8'h02; tick();
      chk("ack_stat", 8'h04, 3'd2, 1'b1);
      wr(IF_A, 8'h00);
      chk("if_clear", 8'h00, 3'd0, 1'b0);

      // Edge beats write and ack in the same cycle
      INT_REQ = 5'h01; CPU_IRQ_ACK = 8'h01; A = IF_A; D_IN = 8'h00; WR = 1'b1;
      tick(); INT_REQ = 5'h00;
      chk("edge_priority", 8'h01, 3'd0, 1'b1);
      wr(IF_A, 8'h00);

      // All flags set with nothing enabled
      wr(IE_A, 8'h00);
      INT_REQ = 5'h1F; tick(); INT_REQ = 5'h00;
      chk("ie_zero", 8'h00, 3'd0, 1'b0);
      rd(IF_A, 8'hFF);

      // Read and write same cycle: read sees old value, write lands
      A = IF_A; D_IN = 8'h00; WR = 1'b1; RD = 1'b1; exp_q.push_back(8'hFF); tick();
      rd(IF_A, 8'hE0);

      // Held request must not retrigger after ack
      wr(IE_A, 8'h1F);
      INT_REQ = 5'h08;
      tick(); chk("held_c1", 8'h08, 3'd3, 1'b1);
      tick(); chk("held_c2", 8'h08, 3'd3, 1'b1);
      CPU_IRQ_ACK = 8'h08; tick(); chk("held_ack", 8'h00, 3'd0, 1'b0);
      for (int c = 4; c <= 10; c++) begin
         tick(); chk($sformatf("held_c%0d", c), 8'h00, 3'd0, 1'b0);
      end
      INT_REQ = 5'h00; tick(); chk("held_low", 8'h00, 3'd0, 1'b0);
      INT_REQ = 5'h08; tick(); chk("held_rise", 8'h08, 3'd3, 1'b1);
      INT_REQ = 5'h00; wr(IF_A, 8'h00);

      // Other addresses ignored; ACK upper bits ignored
      wr(16'h1234, 8'hFF);
      chk("other_wr", 8'h00, 3'd0, 1'b0);
      A = 16'h1234; RD = 1'b1; tick();
      wr(IF_A, 8'h1A);
      chk("multi", 8'h1A, 3'd1, 1'b1);
      CPU_IRQ_ACK = 8'hE0; tick();
      chk("ack_hi", 8'h1A, 3'd1, 1'b1);
      CPU_IRQ_ACK = 8'h12; tick();
      chk("ack_multi", 8'h08, 3'd3, 1'b1);

      // Reset wipes state and ignores concurrent activity
      wr(IF_A, 8'h1F);
      wr(IE_A, 8'hE3);
      chk("pre_reset", 8'h03, 3'd0, 1'b1);
      nRESET = 1'b0; A = IE_A; D_IN = 8'hFF; WR = 1'b1; RD = 1'b1; INT_REQ = 5'h01;
      tick();
      chk("post_reset", 8'h00, 3'd0, 1'b0);
      nRESET = 1'b1;
      rd(IE_A, 8'h00);
      rd(IF_A, 8'hE1);
      INT_REQ = 5'h00;
      tick(); tick();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_missing: %0d reads outstanding expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter IF_ADDR, default 16'hFF0F, address of interrupt-flag register.
REQ-002 SHALL have parameter IE_ADDR, default 16'hFFFF, address of interrupt-enable register.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nRESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port A  input  16  CPU address bus.
REQ-006 SHALL have port D_IN  input  8  CPU write data.
REQ-007 SHALL have port WR  input  1  write strobe, one-cycle, qualified by A.
REQ-008 SHALL have port RD  input  1  read strobe, one-cycle, qualified by A.
REQ-009 SHALL have port D_OUT  output  8  registered read data.
REQ-010 SHALL have port D_OUT_EN  output  1  D_OUT valid this cycle.
REQ-011 SHALL have port INT_REQ  input  5  peripheral request lines: bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
REQ-012 SHALL have port CPU_IRQ_TRIG  output  8  pending-and-enabled vector to CPU core.
REQ-013 SHALL have port CPU_IRQ_ACK  input  8  one-hot acknowledge from CPU core.
REQ-014 SHALL have port INT_VEC  output  3  index of highest-priority pending bit.
REQ-015 SHALL have port WAKE  output  1  any enabled interrupt pending (HALT/STOP exit).

Function
REQ-016 SHALL hold IF[4:0] and IE[7:0] registers plus a 5-bit previous-request register REQ_Q.
REQ-017 SHALL detect a request on bit n when INT_REQ[n]=1 and REQ_Q[n]=0; REQ_Q samples INT_REQ every cycle.
REQ-018 SHALL compute next IF per bit, in priority order: detected edge sets (highest); else WR to IF_ADDR loads D_IN[n]; else CPU_IRQ_ACK[n]=1 clears; else hold.
REQ-019 SHALL clear every IF bit whose ACK bit is set when ACK is multi-hot; ACK bits 5-7 SHALL be ignored.
REQ-020 SHALL load IE with all 8 bits of D_IN on WR to IE_ADDR.
REQ-021 SHALL drive CPU_IRQ_TRIG = {3'b000, IF & IE[4:0]} combinationally from registered state (zero added latency after the IF/IE update).
REQ-022 SHALL drive INT_VEC = index of lowest set bit of CPU_IRQ_TRIG (bit0 highest priority); 3'd0 when none set.
REQ-023 SHALL drive WAKE = |CPU_IRQ_TRIG, independent of any CPU master-enable.
REQ-024 SHALL on RD at IF_ADDR return {3'b111, IF} on D_OUT with D_OUT_EN=1 exactly one cycle later.
REQ-025 SHALL on RD at IE_ADDR return IE on D_OUT with D_OUT_EN=1 one cycle later.
REQ-026 SHALL return the register value as it stood in the RD cycle (before any same-cycle update).
REQ-027 SHALL set D_OUT_EN=0 and D_OUT=8'h00 in cycles not following a matching RD.
REQ-028 SHALL ignore WR/RD to any other address; WR and RD in the same cycle SHALL both take effect.
REQ-029 SHALL keep a request line held high from setting IF more than once; re-trigger requires a low cycle.

Reset
REQ-030 SHALL, while nRESET=0 at a clock edge, set IF=0, IE=0, REQ_Q=0, D_OUT=0, D_OUT_EN=0; CPU_IRQ_TRIG=0, INT_VEC=0, WAKE=0 follow.
REQ-031 SHALL ignore WR, RD, ACK and request edges in any cycle where nRESET=0.
REQ-032 SHALL treat a request line high in the first cycle after reset release as an edge (REQ_Q=0).

Verification
REQ-033 SHALL pass: IE=8'h1F, pulse INT_REQ[2] -> next cycle IF=5'h04, CPU_IRQ_TRIG=8'h04, INT_VEC=2, WAKE=1.
REQ-034 SHALL pass: IF=5'h06, IE=8'h1F, ACK=8'h02 -> IF=5'h04, INT_VEC 1->2 next cycle.
REQ-035 SHALL pass: edge on bit0 in same cycle as ACK=8'h01 and WR IF=8'h00 -> IF[0]=1 afterwards.
REQ-036 SHALL pass: IE=8'h00, INT_REQ=5'h1F edge -> IF=5'h1F, CPU_IRQ_TRIG=0, WAKE=0; read IF_ADDR -> D_OUT=8'hFF one cycle later.
REQ-037 SHALL pass: INT_REQ[3] held high 10 cycles, ACK after cycle 2 -> IF[3]=0 and stays 0 until line drops and rises.
REQ-038 SHALL pass: IF=5'h1F, IE=8'hE3, nRESET=0 one cycle -> all outputs 0; read IE_ADDR afterwards -> 8'h00.
